booth_mul_seq: RTL and testbench
================================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports named i_clk and i_rst.
REQ-002 The block SHALL have these ports, clock and reset first:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst, input, 1: asynchronous active-high reset.
- i_valid, input, 1: operand request.
- o_ready, output, 1: block can accept a request.
- i_op, input, 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- i_data_a, input, 32: multiplicand (rs1).
- i_data_b, input, 32: multiplier (rs2).
- i_flush, input, 1: abort any in-flight operation.
- o_valid, output, 1: result available.
- i_ready, input, 1: consumer accepts the result.
- o_result, output, 32: result word.
- o_busy, output, 1: high in BUSY or DONE.
REQ-003 The block SHALL have no parameters; widths are fixed at XLEN=32.

Function
REQ-004 The block SHALL be a three-state FSM: IDLE, BUSY, DONE.
REQ-005 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-006 A request SHALL be accepted on a rising edge where state is IDLE, i_valid=1 and i_flush=0; the edge latches the operands and i_op and enters BUSY.
REQ-007 Operand extension SHALL be to 33 bits:
- a is sign-extended for MUL, MULH and MULHSU, and zero-extended for MULHU.
- b is sign-extended for MUL and MULH, and zero-extended for MULHSU and MULHU.
REQ-008 BUSY SHALL retire one radix-4 Booth digit per cycle.
- Digit: d = -2*b[2k+1] + b[2k] + b[2k-1], with b[-1]=0; b is extended to 34 bits.
- Multiples: 0, ±a and ±2a, using 35-bit two's-complement arithmetic.
- Accumulator: a 66-bit product, arithmetic right shift by 2 per digit.
REQ-009 BUSY SHALL last exactly 17 cycles, counted by a 5-bit counter 0..16, and then enter DONE.
REQ-010 Latency: for acceptance at edge N, o_valid SHALL first be high in the cycle after edge N+17 (18 edges after acceptance).
REQ-011 o_result SHALL equal product[31:0] for MUL and product[63:32] for the other ops, bit-exact with the RISC-V M extension.
REQ-012 In DONE, o_valid and o_result SHALL hold stable until i_ready=1; that edge returns to IDLE.
REQ-013 There SHALL be no back-to-back acceptance: o_ready is low in the DONE cycle even if i_ready=1.
REQ-014 i_flush=1 on any edge SHALL force IDLE, with no result produced.
- i_flush takes priority over i_valid in IDLE.
- i_flush takes priority over i_ready in DONE.
REQ-015 Corner cases SHALL produce these results:
- MULH of 0x80000000 by 0x80000000 gives 0x40000000.
- MULHU of 0xFFFFFFFF by 0xFFFFFFFF gives 0xFFFFFFFE.
- No overflow is flagged.
REQ-016 o_result SHALL be registered, with no combinational path from inputs to outputs other than o_ready and o_valid, which decode state.

Reset
REQ-017 Asserting i_rst SHALL immediately force IDLE, regardless of the clock.
REQ-018 While i_rst is asserted, o_ready=1, o_valid=0, o_busy=0 and o_result=0; the counter and accumulator SHALL be cleared.
REQ-019 Reset asserted mid-operation SHALL discard that operation; after deassertion the block accepts a new request normally.

Configuration
REQ-020 The macro BOOTH_MUL_ZERO_BYPASS_EN SHALL control the zero bypass.
- Defined: an accepted request with i_data_a=0 or i_data_b=0 goes directly to DONE with o_result=0, so o_valid is high one cycle after acceptance.
- Undefined: every request takes the full 17-cycle BUSY path (REQ-010).
- Results SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- MUL with a=7, b=-3 (0xFFFFFFFD) -> o_result=0xFFFFFFEB; o_valid first high 18 edges after acceptance.
- MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF -> o_result=0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
- MULH with a=b=0x80000000 -> 0x40000000; hold i_ready=0 for 5 cycles -> o_valid and o_result stable throughout, o_ready=0.
- i_flush at BUSY cycle 8 -> IDLE next cycle, no o_valid. Then issue a new MUL 3x5 -> 15.
- i_rst pulse mid-BUSY -> all outputs at reset values immediately; a following request completes correctly.
- MUL with a=0, b=0x12345678 -> 0. With BOOTH_MUL_ZERO_BYPASS_EN defined, o_valid is high 1 cycle after acceptance; without it, after 18 edges.

Source files
------------

// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
//
// Sequential radix-4 Booth multiplier for the RISC-V M-extension multiply
// group (MUL, MULH, MULHSU, MULHU). One Booth digit is retired per cycle,
// so a full operation spends 17 cycles in BUSY before presenting the result.
//
// Handshake (valid/ready, both directions):
//   request : accepted on a rising edge where o_ready=1 (IDLE), i_valid=1
//             and i_flush=0. Operands and i_op are captured on that edge.
//   result  : o_valid=1 (DONE) holds o_result stable until an edge with
//             i_ready=1, which returns the block to IDLE. o_ready stays low
//             throughout DONE, so a new request is never taken on the same
//             edge that retires a result.
//   i_flush : on any edge forces IDLE and drops the operation; it wins over
//             i_valid in IDLE and over i_ready in DONE.
//
// Ports:
//   i_clk      in   1  clock, rising edge
//   i_rst      in   1  asynchronous active-high reset
//   i_valid    in   1  operand request
//   o_ready    out  1  block can accept a request (IDLE)
//   i_op       in   2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_data_a   in  32  multiplicand (rs1)
//   i_data_b   in  32  multiplier (rs2)
//   i_flush    in   1  abort any in-flight operation
//   o_valid    out  1  result available (DONE)
//   i_ready    in   1  consumer accepts the result
//   o_result   out 32  registered result word
//   o_busy     out  1  high in BUSY or DONE
//
// Build option:
//   BOOTH_MUL_ZERO_BYPASS_EN - when defined, a request with a zero operand
//   skips BUSY and goes straight to DONE with a zero result.
// ---------------------------------------------------------------------------
module booth_mul_seq (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_data_a,
   input  logic [31:0] i_data_b,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;
   localparam logic [4:0] LAST_DIGIT = 5'd16;

   state_t      state;
   logic [1:0]  op_reg;
   logic [34:0] a_reg;   // 35-bit two's-complement multiplicand
   // Multiplier window: bit 0 holds b[2k-1] of the current digit, bits 2:1
   // hold b[2k] and b[2k+1]. Shifts right by two per digit.
   logic [34:0] b_reg;
   logic [65:0] acc;
   logic [4:0]  cnt;

   // Operand extension to 33 bits, decoded from the incoming op.
   logic        a_signed;
   logic        b_signed;
   logic [32:0] a_ext;
   logic [32:0] b_ext;

   always_comb begin
      a_signed = (i_op != OP_MULHU);
      b_signed = (i_op != OP_MULHSU) && (i_op != OP_MULHU);
      a_ext    = {a_signed & i_data_a[31], i_data_a};
      b_ext    = {b_signed & i_data_b[31], i_data_b};
   end

   // Booth digit selection: d = -2*b[2k+1] + b[2k] + b[2k-1].
   logic [34:0] multiple;

   always_comb begin
      multiple = '0;
      case (b_reg[2:0])
         3'b001, 3'b010: multiple = a_reg;
         3'b011:         multiple = {a_reg[33:0], 1'b0};
         3'b100:         multiple = -{a_reg[33:0], 1'b0};
         3'b101, 3'b110: multiple = -a_reg;
         default:        multiple = '0;
      endcase
   end

   // Shift-then-add: each new digit lands 32 bits up, and earlier digits
   // drift down by two per cycle, so after 17 digits digit 0 sits at bit 0
   // and the accumulator holds the exact 66-bit product. Every partial sum
   // is bounded by |a| * 2^(2k+1) * 2^(32-2k) < 2^65, so the arithmetic
   // shift never sees a wrapped sign.
   logic [65:0] acc_shift;
   logic [65:0] acc_next;
   logic [31:0] result_sel;

   always_comb begin
      acc_shift  = {{2{acc[65]}}, acc[65:2]};
      acc_next   = acc_shift + ({{31{multiple[34]}}, multiple} << 32);
      result_sel = (op_reg == OP_MUL) ? acc_next[31:0] : acc_next[63:32];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= S_IDLE;
         op_reg   <= OP_MUL;
         a_reg    <= '0;
         b_reg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         o_result <= '0;
      end else if (i_flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  op_reg <= i_op;
                  a_reg  <= {{2{a_ext[32]}}, a_ext};
                  b_reg  <= {b_ext[32], b_ext, 1'b0};
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= S_BUSY;
`ifdef BOOTH_MUL_ZERO_BYPASS_EN
                  if ((i_data_a == 32'd0) || (i_data_b == 32'd0)) begin
                     o_result <= '0;
                     state    <= S_DONE;
                  end
`endif
               end
            end
            S_BUSY: begin
               acc   <= acc_next;
               b_reg <= {{2{b_reg[34]}}, b_reg[34:2]};
               cnt   <= cnt + 5'd1;
               if (cnt == LAST_DIGIT) begin
                  o_result <= result_sel;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (i_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Handshake flags are pure state decodes.
   always_comb begin
      o_ready = (state == S_IDLE);
      o_valid = (state == S_DONE);
      o_busy  = (state != S_IDLE);
   end

endmodule

// File: tb/tb_booth_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_seq
//
// Directed bench for booth_mul_seq. Expected results come from a 64-bit
// multiply of the extended operands; they are queued when a request is
// accepted and popped when the result appears.
// ---------------------------------------------------------------------------
module tb_booth_mul_seq;

`ifdef BOOTH_MUL_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_op;
   logic [31:0] i_data_a;
   logic [31:0] i_data_b;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
   logic        o_busy;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   booth_mul_seq dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_data_a (i_data_a),
      .i_data_b (i_data_b),
      .i_flush  (i_flush),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result),
      .o_busy   (o_busy)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      ea = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
      eb = (op[1] == 1'b1) ? {32'd0, b} : {{32{b[31]}}, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      int w;
      w = 0;
      while (o_ready !== 1'b1 && w < 50) begin
         @(posedge i_clk); #1; w++;
      end
      check({tag, "_ready_before"}, {31'd0, o_ready}, 32'd1);
      i_op = op; i_data_a = a; i_data_b = b; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   // Issues one request, checks latency, hold behaviour and the result.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold, input string tag);
      int edges;
      logic [31:0] first;
      logic [31:0] exp;
      exp_q.push_back(model(op, a, b));
      accept(op, a, b, tag);
      edges = 1;
      while (o_valid !== 1'b1 && edges < 60) begin
         @(posedge i_clk); #1; edges++;
      end
      check({tag, "_latency"}, edges, lat);
      first = o_result;
      for (int i = 0; i < hold; i++) begin
         @(posedge i_clk); #1;
         check({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
         check({tag, "_hold_result"}, o_result, first);
         check({tag, "_hold_ready"}, {31'd0, o_ready}, 32'd0);
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({tag, "_result"}, o_result, exp);
      i_ready = 1'b1;
      #1;
      check({tag, "_ready_in_done"}, {31'd0, o_ready}, 32'd0);
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      check({tag, "_valid_after"}, {31'd0, o_valid}, 32'd0);
      check({tag, "_ready_after"}, {31'd0, o_ready}, 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic saw_valid;
      logic [1:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;

      i_rst = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_data_a = '0; i_data_b = '0;
      i_flush = 1'b0; i_ready = 1'b0;
      #12;
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_busy",  {31'd0, o_busy},  32'd0);
      check("rst_result", o_result, 32'd0);
      @(posedge i_clk); #2;
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // MUL 7 * -3
      run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 18, 0, "mul_7_m3");
      check("mul_7_m3_const", model(2'b00, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);

      // MULHSU / MULHU with all-ones operands
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 0, "mulhsu_ff");
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 0, "mulhu_ff");
      check("mulhu_ff_const", model(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

      // MULH most-negative squared, result held for 5 cycles
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 18, 5, "mulh_min");
      check("mulh_min_const", model(2'b01, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);

      // Flush in BUSY cycle 8
      accept(2'b00, 32'd1234, 32'd5678, "flush");
      repeat (7) begin
         @(posedge i_clk); #1;
      end
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      check("flush_ready", {31'd0, o_ready}, 32'd1);
      check("flush_busy",  {31'd0, o_busy},  32'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (o_valid === 1'b1) saw_valid = 1'b1;
         @(posedge i_clk); #1;
      end
      check("flush_no_valid", {31'd0, saw_valid}, 32'd0);
      run_op(2'b00, 32'd3, 32'd5, 18, 0, "mul_3_5");

      // Flush wins over i_valid in IDLE
      i_op = 2'b00; i_data_a = 32'd9; i_data_b = 32'd9; i_valid = 1'b1; i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_flush = 1'b0;
      check("flush_idle_ready", {31'd0, o_ready}, 32'd1);

      // Asynchronous reset mid-BUSY
      accept(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "rst_mid");
      repeat (5) begin
         @(posedge i_clk); #1;
      end
      #2;
      i_rst = 1'b1;
      #1;
      check("rst_mid_ready",  {31'd0, o_ready}, 32'd1);
      check("rst_mid_valid",  {31'd0, o_valid}, 32'd0);
      check("rst_mid_busy",   {31'd0, o_busy},  32'd0);
      check("rst_mid_result", o_result, 32'd0);
      @(posedge i_clk); #2;
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      run_op(2'b00, 32'hFFFF_FFF9, 32'd6, 18, 0, "after_rst");

      // Zero operand
      run_op(2'b00, 32'd0, 32'h1234_5678, BYPASS ? 1 : 18, 0, "mul_zero");
      run_op(2'b11, 32'hCAFE_F00D, 32'd0, BYPASS ? 1 : 18, 0, "mulhu_zero");

      // Random operands across all ops
      for (int i = 0; i < 8; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         r_b  = $urandom;
         run_op(r_op, r_a, r_b, (BYPASS && (r_a == 0 || r_b == 0)) ? 1 : 18, 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
